// File: rtl/conv_enc_block_scheduler_if.sv
// rtl/conv_enc_block_scheduler_if.sv - Signal bundle between the block scheduler and its surroundings
// master: the scheduler itself; slave: descriptor source, encoder, sub-block FIFOs and rate matcher.
interface conv_enc_block_scheduler_if;
    logic       desc_valid;
    logic       desc_ready;
    logic       desc_len;
    logic [7:0] desc_tail;
    logic       enc_start;
    logic       enc_len;
    logic [7:0] enc_tail;
    logic       enc_done;
    logic       enc_abort;
    logic [2:0] sub_empty;
    logic [2:0] sub_rdreq;
    logic [7:0] sub_q0;
    logic [7:0] sub_q1;
    logic [7:0] sub_q2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_stream;
    logic       out_sop;
    logic       out_eop;
    logic       blk_done;
    logic       busy;
    logic       err_seq;
    logic       err_wdog;

    modport master (
        input  desc_valid, desc_len, desc_tail, enc_done, sub_empty,
               sub_q0, sub_q1, sub_q2, out_ready,
        output desc_ready, enc_start, enc_len, enc_tail, enc_abort, sub_rdreq,
               out_valid, out_data, out_stream, out_sop, out_eop,
               blk_done, busy, err_seq, err_wdog
    );

    modport slave (
        output desc_valid, desc_len, desc_tail, enc_done, sub_empty,
               sub_q0, sub_q1, sub_q2, out_ready,
        input  desc_ready, enc_start, enc_len, enc_tail, enc_abort, sub_rdreq,
               out_valid, out_data, out_stream, out_sop, out_eop,
               blk_done, busy, err_seq, err_wdog
    );
endinterface

// File: rtl/conv_enc_block_scheduler.sv
// rtl/conv_enc_block_scheduler.sv - Per-block encoder sequencer and serial drain of three sub-block FIFOs
// Optional ENCODE watchdog is enabled by defining CONV_SCHED_WDOG_EN.
module conv_enc_block_scheduler #(
    parameter int SMALL_BYTES = 132,
    parameter int LARGE_BYTES = 768,
    parameter int CNT_W       = 10,
    parameter int WDOG_CYCLES = 2048
) (
    input  logic                              clk,
    input  logic                              reset,
    conv_enc_block_scheduler_if.master        bus
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_ENCODE, S_DRAIN} state_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] stream;
        logic       sop;
        logic       eop;
    } beat_t;

    localparam logic [CNT_W-1:0] LP_SMALL_M1 = CNT_W'(SMALL_BYTES - 1);
    localparam logic [CNT_W-1:0] LP_LARGE_M1 = CNT_W'(LARGE_BYTES - 1);

    state_t           r_state, w_state_nxt;
    logic             r_enc_len;
    logic [7:0]       r_enc_tail;
    logic [1:0]       r_stream;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rd_active;
    logic             r_if_valid;
    logic [1:0]       r_if_stream;
    logic             r_if_sop;
    logic             r_if_eop;
    logic [1:0]       r_occ;
    beat_t            r_sk0, r_sk1;
    logic             r_err_seq;
    logic             r_err_wdog;

    logic [CNT_W-1:0] w_n_m1;
    logic             w_pop;
    logic [2:0]       w_level;
    logic             w_rd_en;
    logic             w_last_pop;
    beat_t            w_in_beat;
    logic             w_latch;
    logic             w_drain_load;
    logic             w_enc_start;
    logic             w_enc_abort;
    logic             w_wdog_exp;

    assign w_n_m1     = r_enc_len ? LP_LARGE_M1 : LP_SMALL_M1;
    assign w_pop      = (r_occ != 2'd0) && bus.out_ready;
    // Skid slots still needed after this cycle; a new read is allowed only if one slot stays free.
    assign w_level    = {1'b0, r_occ} + {2'b00, r_if_valid} - {2'b00, w_pop};
    assign w_rd_en    = (r_state == S_DRAIN) && r_rd_active && !bus.sub_empty[r_stream]
                        && (w_level <= 3'd1);
    assign w_last_pop = (r_state == S_DRAIN) && w_pop && r_sk0.eop && (r_sk0.stream == 2'd2);

`ifdef CONV_SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] r_wdog;

    assign w_wdog_exp = (r_state == S_ENCODE) && (r_wdog == WD_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || (r_state != S_ENCODE)) r_wdog <= '0;
        else                                r_wdog <= r_wdog + 1'b1;
    end
`else
    assign w_wdog_exp = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_drain_load = 1'b0;
        w_enc_start  = 1'b0;
        w_enc_abort  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.desc_valid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_enc_start = 1'b1;
                if (bus.enc_done) begin
                    w_drain_load = 1'b1;
                    w_state_nxt  = S_DRAIN;
                end else begin
                    w_state_nxt  = S_ENCODE;
                end
            end
            S_ENCODE: begin
                if (bus.enc_done) begin
                    w_drain_load = 1'b1;
                    w_state_nxt  = S_DRAIN;
                end else if (w_wdog_exp) begin
                    w_enc_abort  = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_last_pop) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_enc_len  <= 1'b0;
            r_enc_tail <= 8'd0;
            r_err_seq  <= 1'b0;
            r_err_wdog <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_enc_len  <= bus.desc_len;
                r_enc_tail <= bus.desc_tail;
            end
            if (bus.enc_done && ((r_state == S_IDLE) || (r_state == S_DRAIN))) r_err_seq <= 1'b1;
            if (w_enc_abort) r_err_wdog <= 1'b1;
        end
    end

    // Read sequencing: r_cnt holds reads left minus one for the current stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stream    <= 2'd0;
            r_cnt       <= '0;
            r_rd_active <= 1'b0;
        end else if (w_drain_load) begin
            r_stream    <= 2'd0;
            r_cnt       <= w_n_m1;
            r_rd_active <= 1'b1;
        end else if (w_rd_en) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (r_stream == 2'd2) begin
                r_rd_active <= 1'b0;
            end else begin
                r_stream <= r_stream + 2'd1;
                r_cnt    <= w_n_m1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_valid  <= 1'b0;
            r_if_stream <= 2'd0;
            r_if_sop    <= 1'b0;
            r_if_eop    <= 1'b0;
        end else begin
            r_if_valid  <= w_rd_en;
            r_if_stream <= r_stream;
            r_if_sop    <= (r_cnt == w_n_m1);
            r_if_eop    <= (r_cnt == '0);
        end
    end

    always_comb begin
        w_in_beat = '{data: bus.sub_q2, stream: r_if_stream, sop: r_if_sop, eop: r_if_eop};
        if (r_if_stream == 2'd0)      w_in_beat.data = bus.sub_q0;
        else if (r_if_stream == 2'd1) w_in_beat.data = bus.sub_q1;
    end

    // Two-entry skid; r_sk0 is always the head presented on the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ <= 2'd0;
            r_sk0 <= '0;
            r_sk1 <= '0;
        end else begin
            case ({r_if_valid, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_sk0 <= w_in_beat;
                    else               r_sk1 <= w_in_beat;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_sk0 <= r_sk1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_sk0 <= w_in_beat;
                    end else begin
                        r_sk0 <= r_sk1;
                        r_sk1 <= w_in_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.desc_ready = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.enc_start  = w_enc_start;
    assign bus.enc_abort  = w_enc_abort;
    assign bus.enc_len    = r_enc_len;
    assign bus.enc_tail   = r_enc_tail;
    assign bus.sub_rdreq  = w_rd_en ? (3'b001 << r_stream) : 3'b000;
    assign bus.out_valid  = (r_occ != 2'd0);
    assign bus.out_data   = r_sk0.data;
    assign bus.out_stream = r_sk0.stream;
    assign bus.out_sop    = r_sk0.sop;
    assign bus.out_eop    = r_sk0.eop;
    assign bus.blk_done   = w_last_pop;
    assign bus.err_seq    = r_err_seq;
    assign bus.err_wdog   = r_err_wdog;
endmodule

// File: tb/tb_conv_enc_block_scheduler.sv
// tb/tb_conv_enc_block_scheduler.sv - Self-checking bench for conv_enc_block_scheduler
module tb_conv_enc_block_scheduler;
    typedef struct packed {
        logic [7:0] d;
        logic [1:0] s;
        logic       sop;
        logic       eop;
    } item_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    conv_enc_block_scheduler_if bus();

    conv_enc_block_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] fq0[$];
    logic [7:0] fq1[$];
    logic [7:0] fq2[$];
    item_t      exp_q[$];
    logic [2:0] gap = 3'b000;
    bit         gap_rand = 1'b0;
    int         ready_mode = 0;
    bit         exp_err_seq = 1'b0;
    int         acc_cnt = 0;
    int         blk_cnt = 0;
    int         start_cnt = 0;
    int         first_rd = -1;
    int         first_ov = -1;
    int         blk_cyc = -1;
    bit         hold = 1'b0;
    item_t      held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sub-block FIFOs: data appears one cycle after the read request, empty flag is registered.
    always @(posedge clk) begin
        logic [2:0] rg;
        cyc++;
        rg = gap_rand ? (3'($urandom) & 3'($urandom)) : 3'b000;
        if (bus.sub_rdreq[0] && fq0.size() > 0) bus.sub_q0 <= fq0.pop_front();
        if (bus.sub_rdreq[1] && fq1.size() > 0) bus.sub_q1 <= fq1.pop_front();
        if (bus.sub_rdreq[2] && fq2.size() > 0) bus.sub_q2 <= fq2.pop_front();
        bus.sub_empty <= {fq2.size() == 0, fq1.size() == 0, fq0.size() == 0} | gap | rg;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = !bus.out_ready;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        item_t e;
        item_t act;
        bit    last;
        if (reset) begin
            hold = 1'b0;
        end else begin
            act  = {bus.out_data, bus.out_stream, bus.out_sop, bus.out_eop};
            last = 1'b0;
            chk("rdreq_onehot", 32'($onehot0(bus.sub_rdreq)), 1);
            chk("rdreq_on_empty", 32'(bus.sub_rdreq & bus.sub_empty), 0);
            chk("desc_ready_vs_busy", 32'(bus.desc_ready), 32'(!bus.busy));
            chk("err_seq", 32'(bus.err_seq), 32'(exp_err_seq));
`ifndef CONV_SCHED_WDOG_EN
            chk("enc_abort_off", 32'(bus.enc_abort), 0);
            chk("err_wdog_off", 32'(bus.err_wdog), 0);
`endif
            if (bus.enc_start) start_cnt++;
            if (bus.sub_rdreq != 3'b000 && first_rd < 0) first_rd = cyc;
            if (bus.out_valid && first_ov < 0) first_ov = cyc;
            if (hold) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_beat", 32'(act), 32'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", act);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", 32'(act), 32'(e));
                    last = e.eop && (e.s == 2'd2);
                end
                acc_cnt++;
            end
            chk("blk_done", 32'(bus.blk_done), 32'(last));
            if (bus.blk_done) begin
                blk_cnt++;
                blk_cyc = cyc;
            end
            hold = bus.out_valid && !bus.out_ready;
            held = act;
        end
    end

    task automatic load_block(input bit len);
        int         n;
        logic [7:0] b;
        n = len ? 768 : 132;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                if (s == 0)      fq0.push_back(b);
                else if (s == 1) fq1.push_back(b);
                else             fq2.push_back(b);
                exp_q.push_back('{d: b, s: 2'(s), sop: (i == 0), eop: (i == n - 1)});
            end
        end
    endtask

    task automatic run_block(input bit len, input logic [7:0] tail, input int delay,
                             input bit timing, input int exp_bytes);
        int k, b0, a0, s0;
        load_block(len);
        tick();
        tick();
        first_rd = -1;
        first_ov = -1;
        a0 = acc_cnt;
        b0 = blk_cnt;
        s0 = start_cnt;
        bus.desc_valid = 1'b1;
        bus.desc_len   = len;
        bus.desc_tail  = tail;
        k = 0;
        while (!bus.desc_ready && k < 100) begin
            tick();
            k++;
        end
        tick();
        bus.desc_valid = 1'b0;
        bus.desc_len   = 1'($urandom);
        bus.desc_tail  = 8'($urandom);
        if (delay == 0) bus.enc_done = 1'b1;
        @(negedge clk);
        chk("enc_start", 32'(bus.enc_start), 1);
        chk("enc_len", 32'(bus.enc_len), 32'(len));
        chk("enc_tail", 32'(bus.enc_tail), 32'(tail));
        if (delay != 0) repeat (delay) tick();
        else            tick();
        bus.enc_done = (delay != 0);
        tick();
        bus.enc_done = 1'b0;
        k = 0;
        while (blk_cnt == b0 && k < 20000) begin
            tick();
            k++;
        end
        repeat (3) tick();
        chk("blk_count", 32'(blk_cnt - b0), 1);
        chk("bytes", 32'(acc_cnt - a0), 32'(exp_bytes));
        chk("leftover", 32'(exp_q.size()), 0);
        chk("start_pulses", 32'(start_cnt - s0), 1);
        chk("tail_held", 32'(bus.enc_tail), 32'(tail));
        if (timing) begin
            chk("latency", 32'(first_ov - first_rd), 2);
            chk("drain_cycles", 32'(blk_cyc - first_rd), 32'(exp_bytes + 1));
        end
    endtask

    initial begin
        int k, a0, aborts, rd;
        bus.desc_valid = 1'b0;
        bus.desc_len   = 1'b0;
        bus.desc_tail  = 8'd0;
        bus.enc_done   = 1'b0;
        bus.sub_empty  = 3'b111;
        bus.sub_q0     = 8'd0;
        bus.sub_q1     = 8'd0;
        bus.sub_q2     = 8'd0;
        bus.out_ready  = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_desc_ready", 32'(bus.desc_ready), 1);
        chk("rst_outputs", 32'({bus.enc_start, bus.enc_len, bus.enc_tail, bus.enc_abort, bus.sub_rdreq,
                                bus.out_valid, bus.blk_done, bus.busy, bus.err_seq, bus.err_wdog}), 0);
        tick();
        reset = 1'b0;

        ready_mode = 0;
        run_block(1'b0, 8'hA5, 5, 1'b1, 396);

        ready_mode = 1;
        run_block(1'b1, 8'h3C, 9, 1'b0, 2304);

        ready_mode = 0;
        a0 = acc_cnt;
        fork
            run_block(1'b0, 8'h71, 2, 1'b0, 396);
            begin
                k = 0;
                while (acc_cnt < a0 + 172 && k < 5000) begin
                    tick();
                    k++;
                end
                gap[1] = 1'b1;
                repeat (20) tick();
                gap[1] = 1'b0;
            end
        join

        load_block(1'b0);
        tick();
        tick();
        a0 = acc_cnt;
        bus.desc_valid = 1'b1;
        bus.desc_len   = 1'b0;
        tick();
        bus.desc_valid = 1'b0;
        tick();
        bus.enc_done = 1'b1;
        tick();
        bus.enc_done = 1'b0;
        k = 0;
        while (acc_cnt < a0 + 10 && k < 1000) begin
            tick();
            k++;
        end
        k = 0;
        while (bus.sub_rdreq == 3'b000 && k < 1000) begin
            tick();
            k++;
        end
        chk("rdreq_before_reset", 32'(bus.sub_rdreq != 3'b000), 1);
        tick();
        reset = 1'b1;
        exp_err_seq = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_desc_ready", 32'(bus.desc_ready), 1);
        chk("midrst_busy_rdreq", 32'({bus.busy, bus.sub_rdreq}), 0);
        tick();
        fq0.delete();
        fq1.delete();
        fq2.delete();
        exp_q.delete();
        reset = 1'b0;
        tick();
        run_block(1'b0, 8'h0F, 3, 1'b1, 396);

        ready_mode = 2;
        gap_rand   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit ln;
            ln = ($urandom_range(0, 3) == 0);
            run_block(ln, 8'($urandom), $urandom_range(0, 8), 1'b0, ln ? 2304 : 396);
        end
        gap_rand   = 1'b0;
        ready_mode = 0;

`ifdef CONV_SCHED_WDOG_EN
        bus.desc_valid = 1'b1;
        tick();
        bus.desc_valid = 1'b0;
        k = 0;
        aborts = 0;
        rd = 0;
        while (bus.busy && k < 3000) begin
            if (bus.enc_abort) aborts++;
            if (bus.sub_rdreq != 3'b000) rd++;
            tick();
            k++;
        end
        chk("wdog_abort_pulses", 32'(aborts), 1);
        chk("wdog_busy_cycles", 32'(k), 2049);
        chk("wdog_rdreq", 32'(rd), 0);
        chk("wdog_flag", 32'(bus.err_wdog), 1);
`else
        aborts = 0;
        rd = 0;
`endif

        tick();
        bus.enc_done = 1'b1;
        tick();
        bus.enc_done = 1'b0;
        exp_err_seq  = 1'b1;
        @(negedge clk);
        chk("seq_err_set", 32'(bus.err_seq), 1);
        chk("seq_err_idle", 32'({bus.busy, bus.desc_ready}), 32'b01);
        repeat (5) tick();
        chk("seq_err_sticky", 32'(bus.err_seq), 1);
        reset = 1'b1;
        exp_err_seq = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("seq_err_cleared", 32'(bus.err_seq), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
